// File: rtl/prop_stim_pkg.sv
// Shared types and constants for the procedural-assumption stimulus generator.
package prop_stim_pkg;

   typedef enum logic [1:0] {
      WALK = 2'd0,
      LFSR = 2'd1,
      ONES = 2'd2,
      ZERO = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam logic [15:0] LFSR_POLY    = 16'hB400;
   localparam int          DRAIN_CYCLES = 2;

   // One Galois step: shift right, fold the polynomial in when a one falls out.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/prop_stim_gen_if.sv
// Control and traffic bundle between the stimulus generator and its consumer.
// PROP_STIM_FAULT_EN adds the inject_fault request line.
interface prop_stim_gen_if #(
   parameter int WIDTH = 11
);
   logic             start;
   logic [1:0]       mode;
   logic             act_cond;
   logic [WIDTH-1:0] foo;
   logic [WIDTH-1:0] bar;
   logic             w;
   logic             busy;
   logic             done;
   logic [7:0]       burst_cnt;
`ifdef PROP_STIM_FAULT_EN
   logic             inject_fault;

   modport master (
      input  start, mode, inject_fault,
      output act_cond, foo, bar, w, busy, done, burst_cnt
   );
   modport slave (
      output start, mode, inject_fault,
      input  act_cond, foo, bar, w, busy, done, burst_cnt
   );
`else
   modport master (
      input  start, mode,
      output act_cond, foo, bar, w, busy, done, burst_cnt
   );
   modport slave (
      output start, mode,
      input  act_cond, foo, bar, w, busy, done, burst_cnt
   );
`endif
endinterface

// File: rtl/prop_stim_lfsr.sv
// 16-bit Galois LFSR with a zero-seed guard; advances only when adv is high.
module prop_stim_lfsr
   import prop_stim_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        adv,
   output logic [15:0] state
);
   // An all-zero state would lock up, so a zero seed becomes 1.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] state_r;

   // LFSR state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= SEED_EFF;
      end else if (adv) begin
         state_r <= lfsr_step(state_r);
      end else begin
         state_r <= state_r;
      end
   end

   assign state = state_r;

endmodule

// File: rtl/prop_stim_gen.sv
// Bounded-burst stimulus generator producing traffic that satisfies
// foo[i] |=> bar[i] ##1 w. Define PROP_STIM_FAULT_EN to add inject_fault.
module prop_stim_gen
   import prop_stim_pkg::*;
#(
   parameter int          WIDTH     = 11,
   parameter int          BURST_LEN = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input logic             clk,
   input logic             rst_n,
   prop_stim_gen_if.master bus
);
   localparam logic [WIDTH-1:0] WALK_INIT = WIDTH'(1'b1);
   localparam logic [WIDTH-1:0] ALL_ZERO  = {WIDTH{1'b0}};

   state_e           state_r;
   mode_e            mode_r;
   mode_e            mode_in_s;
   logic [WIDTH-1:0] foo_r;
   logic [WIDTH-1:0] bar_r;
   logic [WIDTH-1:0] walk_r;
   logic [WIDTH-1:0] fault_mask_s;
   logic             w_pipe_r;
   logic             w_r;
   logic             act_cond_r;
   logic             busy_r;
   logic             done_r;
   logic [7:0]       burst_cnt_r;
   logic [1:0]       drain_cnt_r;
   logic [15:0]      lfsr_state_s;
   logic             lfsr_adv_s;
   logic             accept_s;
   logic             last_s;

   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x);
      return (x << 1) | (x >> (WIDTH - 1));
   endfunction

   function automatic logic [WIDTH-1:0] pattern(input mode_e md,
                                                input logic [WIDTH-1:0] walk,
                                                input logic [15:0] lfsr);
      logic [WIDTH-1:0] p;
      case (md)
         WALK:    p = walk;
         LFSR:    p = lfsr[WIDTH-1:0];
         ONES:    p = {WIDTH{1'b1}};
         ZERO:    p = ALL_ZERO;
         default: p = ALL_ZERO;
      endcase
      return p;
   endfunction

   prop_stim_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (lfsr_adv_s),
      .state (lfsr_state_s)
   );

   assign mode_in_s = mode_e'(bus.mode);

   // Burst control decode; the LFSR steps once per LFSR pattern it supplies
   always_comb begin
      accept_s = (state_r == IDLE) && bus.start;
      last_s   = (state_r == RUN) && (burst_cnt_r == 8'(BURST_LEN - 1));
      if (accept_s) begin
         lfsr_adv_s = (mode_in_s == LFSR);
      end else if ((state_r == RUN) && !last_s) begin
         lfsr_adv_s = (mode_r == LFSR);
      end else begin
         lfsr_adv_s = 1'b0;
      end
   end

   // Burst FSM with registered foo/act_cond/busy/done/burst_cnt
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         mode_r      <= WALK;
         foo_r       <= ALL_ZERO;
         walk_r      <= WALK_INIT;
         act_cond_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         burst_cnt_r <= 8'd0;
         drain_cnt_r <= 2'd0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r     <= RUN;
                  mode_r      <= mode_in_s;
                  foo_r       <= pattern(mode_in_s, WALK_INIT, lfsr_state_s);
                  walk_r      <= rotl(WALK_INIT);
                  act_cond_r  <= 1'b1;
                  busy_r      <= 1'b1;
                  burst_cnt_r <= 8'd0;
                  drain_cnt_r <= 2'd0;
               end else begin
                  foo_r      <= ALL_ZERO;
                  act_cond_r <= 1'b0;
                  busy_r     <= 1'b0;
               end
            end
            RUN: begin
               burst_cnt_r <= burst_cnt_r + 8'd1;
               if (last_s) begin
                  state_r     <= DRAIN;
                  foo_r       <= ALL_ZERO;
                  drain_cnt_r <= 2'd0;
               end else begin
                  foo_r  <= pattern(mode_r, walk_r, lfsr_state_s);
                  walk_r <= rotl(walk_r);
               end
            end
            DRAIN: begin
               foo_r <= ALL_ZERO;
               if (drain_cnt_r == 2'(DRAIN_CYCLES - 1)) begin
                  state_r    <= IDLE;
                  act_cond_r <= 1'b0;
                  busy_r     <= 1'b0;
                  done_r     <= 1'b1;
               end else begin
                  drain_cnt_r <= drain_cnt_r + 2'd1;
               end
            end
            default: begin
               state_r    <= IDLE;
               foo_r      <= ALL_ZERO;
               act_cond_r <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

`ifdef PROP_STIM_FAULT_EN
   assign fault_mask_s = ~(WIDTH'(bus.inject_fault));
`else
   assign fault_mask_s = {WIDTH{1'b1}};
`endif

   // Response pipeline: bar lags foo by one cycle, w lags |foo by two
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bar_r    <= ALL_ZERO;
         w_pipe_r <= 1'b0;
         w_r      <= 1'b0;
      end else begin
         bar_r    <= foo_r & fault_mask_s;
         w_pipe_r <= |foo_r;
         w_r      <= w_pipe_r;
      end
   end

   assign bus.act_cond  = act_cond_r;
   assign bus.foo       = foo_r;
   assign bus.bar       = bar_r;
   assign bus.w         = w_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.burst_cnt = burst_cnt_r;

endmodule

// File: tb/tb_prop_stim_gen.sv
// Directed bench for prop_stim_gen (WIDTH=11, BURST_LEN=16, seed 16'hACE1).
module tb_prop_stim_gen;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   logic [15:0] lfsr_m;
   logic [10:0] lfsr_hand [7];

   prop_stim_gen_if #(.WIDTH(11)) bus ();

   prop_stim_gen #(.WIDTH(11), .BURST_LEN(16), .LFSR_SEED(16'hACE1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".foo"}, 32'(bus.foo), 32'd0);
      chk({tag, ".bar"}, 32'(bus.bar), 32'd0);
      chk({tag, ".w"}, 32'(bus.w), 32'd0);
      chk({tag, ".act"}, 32'(bus.act_cond), 32'd0);
      chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
      chk({tag, ".done"}, 32'(bus.done), 32'd0);
   endtask

   // Called at burst cycle 0 (just after the accepting edge); returns at the done cycle.
   task automatic run_burst(input logic [1:0] md, input string tag, input bit poke_start);
      logic [10:0] exp_foo;
      logic [10:0] pf1;
      logic [10:0] pf2;
      pf1 = 11'd0;
      pf2 = 11'd0;
      for (int k = 0; k < 18; k++) begin
         if (k < 16) begin
            case (md)
               2'd0: exp_foo = 11'd1 << (k % 11);
               2'd1: begin
                  exp_foo = lfsr_m[10:0];
                  lfsr_m  = (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
               end
               2'd2: exp_foo = 11'h7FF;
               default: exp_foo = 11'd0;
            endcase
         end else begin
            exp_foo = 11'd0;
         end
         if (md == 2'd1 && k < 7) chk({tag, ".lfsr_hand"}, 32'(bus.foo), 32'(lfsr_hand[k]));
         chk({tag, ".foo"}, 32'(bus.foo), 32'(exp_foo));
         chk({tag, ".bar"}, 32'(bus.bar), 32'(pf1));
         chk({tag, ".w"}, 32'(bus.w), 32'(pf2 != 11'd0));
         chk({tag, ".act"}, 32'(bus.act_cond), 32'd1);
         chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
         chk({tag, ".done"}, 32'(bus.done), 32'd0);
         chk({tag, ".cnt"}, 32'(bus.burst_cnt), (k < 16) ? 32'(k) : 32'd16);
         pf2 = pf1;
         pf1 = exp_foo;
         bus.start = (poke_start && k == 5) ? 1'b1 : 1'b0;
         bus.mode  = bus.mode ^ 2'b01;
         step();
      end
      bus.start = 1'b0;
      chk({tag, ".done_pulse"}, 32'(bus.done), 32'd1);
      chk({tag, ".end_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, ".end_act"}, 32'(bus.act_cond), 32'd0);
      chk({tag, ".end_foo"}, 32'(bus.foo), 32'd0);
      chk({tag, ".end_bar"}, 32'(bus.bar), 32'(pf1));
      chk({tag, ".end_w"}, 32'(bus.w), 32'(pf2 != 11'd0));
      chk({tag, ".end_cnt"}, 32'(bus.burst_cnt), 32'd16);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      lfsr_m = 16'hACE1;
      lfsr_hand[0] = 11'h4E1;
      lfsr_hand[1] = 11'h270;
      lfsr_hand[2] = 11'h138;
      lfsr_hand[3] = 11'h09C;
      lfsr_hand[4] = 11'h44E;
      lfsr_hand[5] = 11'h627;
      lfsr_hand[6] = 11'h313;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.mode  = 2'd0;
`ifdef PROP_STIM_FAULT_EN
      bus.inject_fault = 1'b0;
`endif
      step();
      chk_quiet("reset");
      chk("reset.cnt", 32'(bus.burst_cnt), 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_quiet("idle");
      end

      // Walking-one burst
      bus.start = 1'b1;
      bus.mode  = 2'd0;
      step();
      run_burst(2'd0, "walk", 1'b0);
      step();
      chk_quiet("gap");

      // All-ones burst chained back-to-back into an LFSR burst
      bus.start = 1'b1;
      bus.mode  = 2'd2;
      step();
      run_burst(2'd2, "ones", 1'b0);
      bus.start = 1'b1;
      bus.mode  = 2'd1;
      step();
      run_burst(2'd1, "lfsr", 1'b0);

      // All-zero burst with a stray start in mid-burst
      step();
      bus.start = 1'b1;
      bus.mode  = 2'd3;
      step();
      run_burst(2'd3, "zero", 1'b1);

      // Reset in RUN cycle 5 aborts without done
      step();
      bus.start = 1'b1;
      bus.mode  = 2'd0;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("abort.pre_foo", 32'(bus.foo), 32'h020);
      rst_n = 1'b0;
      step();
      chk_quiet("abort");
      chk("abort.cnt", 32'(bus.burst_cnt), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_quiet("post_abort");
      end
      bus.start = 1'b1;
      bus.mode  = 2'd0;
      step();
      run_burst(2'd0, "restart", 1'b0);

`ifdef PROP_STIM_FAULT_EN
      step();
      bus.start = 1'b1;
      bus.mode  = 2'd0;
      step();
      bus.start = 1'b0;
      chk("fault.foo", 32'(bus.foo), 32'h001);
      bus.inject_fault = 1'b1;
      step();
      bus.inject_fault = 1'b0;
      chk("fault.bar", 32'(bus.bar), 32'h000);
      for (int i = 0; i < 20; i++) step();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prop_stim_gen.md
# prop_stim_gen

Stimulus generator sitting directly upstream of the procedural-assumption checker. It drives the activation condition, the `foo` request vector, the `bar` response vector and the `w` completion line. Generated traffic satisfies `foo[i] |=> bar[i] ##1 (w==1)` on every lane by construction. It runs bounded bursts of configurable patterns, so formal and simulation environments get legal, reproducible traffic for the checker.

## Interface
Parameters:
- WIDTH, 11, lane count of foo/bar; legal range 1..16.
- BURST_LEN, 16, patterns emitted per burst; legal range 1..255.
- LFSR_SEED, 16'hACE1, LFSR reset value; a zero value is replaced by 16'h0001.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  reset; synchronous and active-low.
- start  input  1  one-cycle request to begin a burst; honoured only in IDLE.
- mode  input  2  pattern select, sampled with start: 0 walking-one, 1 LFSR, 2 all-ones, 3 all-zero.
- act_cond  output  1  activation condition for the checker.
- foo  output  WIDTH  request vector.
- bar  output  WIDTH  response vector.
- w  output  1  completion line.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse on burst completion.
- burst_cnt  output  8  patterns emitted in the current or last burst.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - foo=0 and act_cond=0.
  - On start=1, latch mode, clear burst_cnt and the drain counter, then go to RUN.
- RUN:
  - Each cycle, foo presents one pattern, act_cond=1, and burst_cnt increments.
  - After pattern BURST_LEN is presented, go to DRAIN.
- Pattern rules:
  - Walking-one: first pattern is 1, each subsequent pattern shifts left by 1, and bit WIDTH-1 wraps to bit 0.
  - LFSR: 16-bit Galois, polynomial mask 16'hB400, shift right; foo = low WIDTH bits of the current state; the state advances once per RUN cycle.
  - All-ones and all-zero: constant patterns.
- DRAIN:
  - Lasts exactly 2 cycles with foo=0 and act_cond=1, so the obligations of the last patterns complete under activation.
  - Then return to IDLE with done=1 for one cycle, concurrent with the first IDLE cycle.
- Response path, independent of state:
  - bar = foo registered once.
  - w = (|foo) registered twice.
  - w may also be 1 in other cycles only where the rule above sets it; no spurious w.
- start during RUN or DRAIN is ignored. mode changes outside an accepted start are ignored.
- The LFSR state persists across bursts; it is reset only by rst_n.

## Timing
- Reset values at the first posedge with rst_n=0:
  - state=IDLE, foo=0, bar=0, w=0, act_cond=0, busy=0, done=0, burst_cnt=0.
  - LFSR=LFSR_SEED (zero seed replaced by 16'h0001); the walking-one register is 1.
- Reset mid-burst aborts the burst with no done pulse; the response pipeline is flushed to 0.
- start accepted at edge t: first pattern visible after edge t; busy=1 from the same edge.
- For a pattern P on foo in cycle c: bar=P in cycle c+1, and w=1 in cycle c+2 iff P≠0.
- Burst length in cycles: BURST_LEN RUN + 2 DRAIN. done is high in cycle BURST_LEN+2 after acceptance.
- start in the same cycle as done (state already IDLE) is accepted, giving back-to-back bursts.

## Configuration
- PROP_STIM_FAULT_EN defined:
  - Adds input `inject_fault` (1 bit).
  - When inject_fault=1, bar[0] is forced to 0 in the next cycle, creating a deliberate assumption violation for negative tests.
- PROP_STIM_FAULT_EN undefined: port absent; bar is always exactly the registered foo.

## Structure
- Package `prop_stim_pkg`:
  - mode enum: WALK, LFSR, ONES, ZERO.
  - state enum: IDLE, RUN, DRAIN.
  - Constants: LFSR_POLY=16'hB400, DRAIN_CYCLES=2.
- One sub-module, `prop_stim_lfsr`: 16-bit Galois LFSR with seed, zero-seed guard, and an advance enable.

## Test plan
- Reset then idle 10 cycles -> foo=bar=0, w=0, act_cond=0, busy=0, done=0.
- start with mode=0, WIDTH=11, BURST_LEN=16 -> foo sequence 0x001,0x002,…,0x400,0x001,…,0x010. bar is the same sequence lagged 1 cycle, w=1 lagged 2 cycles. done in cycle 18; burst_cnt=16.
- mode=2 burst, then start asserted in the done cycle with mode=1 -> second burst begins with no idle gap; LFSR low 11 bits of 16'hACE1 advance per cycle; property holds on all lanes.
- mode=3 burst -> act_cond=1 for 18 cycles, foo=bar=0, w stays 0, done pulses.
- rst_n=0 asserted in RUN cycle 5 -> all outputs 0 at the next edge, no done, and the next start restarts the walking-one at 0x001.
- With PROP_STIM_FAULT_EN, inject_fault=1 while foo[0]=1 -> bar[0]=0 in the next cycle; checker reports a violation.
